part_sram_wxd: RTL and testbench

Parametrised synchronous static RAM, the generalised successor of the 32x2 bipolar RAM part model. Width, depth and read-during-write behaviour are parameters. Per-bit write enables, a holdable address latch and a registered read port are retained. A built-in clear sequencer zeroes the array after reset or on request, so microcode and map RAMs start from a known state without testbench preloading.

---
 rtl/sram_pkg.sv | 13 +
 rtl/sram_clear_seq.sv | 66 ++++++
 rtl/part_sram_wxd.sv | 119 +++++++++++
 tb/tb_part_sram_wxd.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants for the parametrised SRAM part.
// Read-during-write modes and clear sequencer states.
package sram_pkg;

    localparam int RDW_OLD           = 0;
    localparam int RDW_WRITE_THROUGH = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } seq_state_e;

endpackage

// File: rtl/sram_clear_seq.sv
// Clear sequencer: sweeps zeros over the array.
// Owns the sweep counter, FSM and busy flag.
import sram_pkg::*;

module sram_clear_seq #(
    parameter int AWIDTH         = 5,
    parameter int DEPTH          = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [AWIDTH-1:0] clr_addr
);

    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [AWIDTH-1:0] cnt_q;
    logic [AWIDTH-1:0] cnt_d;

    // State and counter registers; reset may restart or abort a sweep
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? SWEEP : IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: requests while sweeping are ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == SWEEP);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/part_sram_wxd.sv
// Parametrised synchronous RAM with per-bit write enables,
// address latch, registered read and built-in clear sweep.
import sram_pkg::*;

module part_sram_wxd #(
    parameter int WIDTH          = 2,
    parameter int AWIDTH         = 5,
    parameter int DEPTH          = 32,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              latch,
    input  logic [AWIDTH-1:0] a,
    input  logic [WIDTH-1:0]  din,
    input  logic [WIDTH-1:0]  we,
    input  logic              clear_req,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    output logic              busy
);

    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AWIDTH-1:0] a_q;
    logic [AWIDTH-1:0] ea;
    logic              in_range;
    logic              acc;
    logic [WIDTH-1:0]  old_word;
    logic [WIDTH-1:0]  rd_word;
    logic              clr_we;
    logic [AWIDTH-1:0] clr_addr;
    logic [AWIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_mask;
    logic [WIDTH-1:0]  wr_data;

    sram_clear_seq #(
        .AWIDTH         (AWIDTH),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign ea       = latch ? a : a_q;
    assign in_range = ({1'b0, ea} < DEPTH_W);
    assign acc      = ce && !busy && !reset;

    // Read data path, including the read-during-write merge
    always_comb begin
        old_word = '0;
        if (in_range) begin
            old_word = mem[ea];
        end
        rd_word = old_word;
        if (RDW_MODE == RDW_WRITE_THROUGH) begin
            rd_word = (we & din) | (~we & old_word);
        end
        if (!in_range) begin
            rd_word = '0;
        end
    end

    // Write port mux: the clear sweep owns the array while busy
    always_comb begin
        wr_addr = ea;
        wr_data = din;
        wr_mask = '0;
        if (clr_we) begin
            wr_addr = clr_addr;
            wr_data = '0;
            wr_mask = '1;
        end else if (acc && in_range) begin
            wr_mask = we;
        end
    end

    // Array storage, per-bit masked; no writes land on a reset cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_addr][i] <= wr_data[i];
                end
            end
        end
    end

    // Address latch, transparent whenever latch is high
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
        end else if (latch) begin
            a_q <= a;
        end
    end

    // Registered read port; dout holds when no access occurs
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= acc;
            if (acc) begin
                dout <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_part_sram_wxd.sv
// Directed bench for part_sram_wxd: default part, write-through
// variant and a 20-word variant share one input stimulus.
module tb_part_sram_wxd;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       latch;
    logic [4:0] a;
    logic [1:0] din;
    logic [1:0] we;
    logic       clear_req;

    logic [1:0] dout0, dout1, dout2;
    logic       valid0, valid1, valid2;
    logic       busy0, busy1, busy2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    part_sram_wxd #(.RDW_MODE(0)) u0 (
        .clk(clk), .reset(reset), .ce(ce), .latch(latch), .a(a),
        .din(din), .we(we), .clear_req(clear_req),
        .dout(dout0), .dout_valid(valid0), .busy(busy0)
    );

    part_sram_wxd #(.RDW_MODE(1)) u1 (
        .clk(clk), .reset(reset), .ce(ce), .latch(latch), .a(a),
        .din(din), .we(we), .clear_req(clear_req),
        .dout(dout1), .dout_valid(valid1), .busy(busy1)
    );

    part_sram_wxd #(.DEPTH(20)) u2 (
        .clk(clk), .reset(reset), .ce(ce), .latch(latch), .a(a),
        .din(din), .we(we), .clear_req(clear_req),
        .dout(dout2), .dout_valid(valid2), .busy(busy2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n0;
        int n2;
        reset = 1'b1; ce = 1'b0; latch = 1'b1; a = '0;
        din = '0; we = '0; clear_req = 1'b0;
        cyc();
        cyc();
        checks++;
        if (busy0 !== 1'b1 || dout0 !== 2'b00 || valid0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b dout=%b valid=%b want 1 00 0",
                     busy0, dout0, valid0);
        end
        reset = 1'b0;
        n0 = 0;
        n2 = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy0) n0++;
            if (busy2) n2++;
            cyc();
        end
        checks++;
        if (n0 !== 32) begin
            errors++;
            $display("FAIL reset_sweep32 busy_cycles=%0d want 32", n0);
        end
        checks++;
        if (n2 !== 20) begin
            errors++;
            $display("FAIL reset_sweep20 busy_cycles=%0d want 20", n2);
        end
        ce = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            cyc();
            checks++;
            if (dout0 !== 2'b00 || valid0 !== 1'b1) begin
                errors++;
                $display("FAIL reset_clear_read addr=%0d dout=%b valid=%b want 00 1",
                         i, dout0, valid0);
            end
        end
    endtask

    task automatic test_bit_we();
        ce = 1'b1; latch = 1'b1; a = 5'd5;
        din = 2'b11; we = 2'b11;
        cyc();
        din = 2'b00; we = 2'b01;
        cyc();
        we = 2'b00;
        cyc();
        checks++;
        if (dout0 !== 2'b10 || dout1 !== 2'b10) begin
            errors++;
            $display("FAIL bit_we dout0=%b dout1=%b want 10", dout0, dout1);
        end
    endtask

    task automatic test_rdw();
        ce = 1'b1; latch = 1'b1; a = 5'd3;
        din = 2'b01; we = 2'b11;
        cyc();
        din = 2'b10; we = 2'b11;
        cyc();
        checks++;
        if (dout0 !== 2'b01) begin
            errors++;
            $display("FAIL rdw_old dout=%b want 01", dout0);
        end
        checks++;
        if (dout1 !== 2'b10) begin
            errors++;
            $display("FAIL rdw_through dout=%b want 10", dout1);
        end
        we = 2'b00;
        cyc();
        checks++;
        if (dout0 !== 2'b10 || dout1 !== 2'b10) begin
            errors++;
            $display("FAIL rdw_after dout0=%b dout1=%b want 10", dout0, dout1);
        end
    endtask

    task automatic test_latch();
        ce = 1'b0; latch = 1'b1; a = 5'd7; we = 2'b00;
        cyc();
        ce = 1'b1; latch = 1'b0; a = 5'd9;
        din = 2'b11; we = 2'b11;
        cyc();
        checks++;
        if (dout0 !== 2'b00 || valid0 !== 1'b1) begin
            errors++;
            $display("FAIL latch_hold_read dout=%b valid=%b want 00 1",
                     dout0, valid0);
        end
        latch = 1'b1; a = 5'd7; we = 2'b00;
        cyc();
        checks++;
        if (dout0 !== 2'b11) begin
            errors++;
            $display("FAIL latch_word7 dout=%b want 11", dout0);
        end
        a = 5'd9;
        cyc();
        checks++;
        if (dout0 !== 2'b00) begin
            errors++;
            $display("FAIL latch_word9 dout=%b want 00", dout0);
        end
        ce = 1'b0; a = 5'd7;
        cyc();
        checks++;
        if (valid0 !== 1'b0 || dout0 !== 2'b00) begin
            errors++;
            $display("FAIL no_access valid=%b dout=%b want 0 00", valid0, dout0);
        end
    endtask

    task automatic test_clear();
        int n0;
        int n2;
        ce = 1'b1; latch = 1'b1; din = 2'b11; we = 2'b11;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            cyc();
        end
        we = 2'b00; a = 5'd31;
        cyc();
        checks++;
        if (dout0 !== 2'b11) begin
            errors++;
            $display("FAIL fill_word31 dout=%b want 11", dout0);
        end
        ce = 1'b0; clear_req = 1'b1;
        cyc();
        n0 = 0;
        n2 = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy0) n0++;
            if (busy2) n2++;
            clear_req = (k == 10);
            cyc();
        end
        clear_req = 1'b0;
        checks++;
        if (n0 !== 32) begin
            errors++;
            $display("FAIL clear_sweep32 busy_cycles=%0d want 32", n0);
        end
        checks++;
        if (n2 !== 20) begin
            errors++;
            $display("FAIL clear_sweep20 busy_cycles=%0d want 20", n2);
        end
        ce = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            cyc();
            checks++;
            if (dout0 !== 2'b00 || valid0 !== 1'b1) begin
                errors++;
                $display("FAIL clear_read addr=%0d dout=%b valid=%b want 00 1",
                         i, dout0, valid0);
            end
        end
    endtask

    task automatic test_out_of_range();
        ce = 1'b1; latch = 1'b1;
        a = 5'd19; din = 2'b01; we = 2'b11;
        cyc();
        a = 5'd25; din = 2'b11; we = 2'b11;
        cyc();
        checks++;
        if (dout2 !== 2'b00 || valid2 !== 1'b1) begin
            errors++;
            $display("FAIL oor_write_read dout=%b valid=%b want 00 1",
                     dout2, valid2);
        end
        we = 2'b00;
        cyc();
        checks++;
        if (dout2 !== 2'b00 || valid2 !== 1'b1) begin
            errors++;
            $display("FAIL oor_read dout=%b valid=%b want 00 1", dout2, valid2);
        end
        checks++;
        if (dout0 !== 2'b11) begin
            errors++;
            $display("FAIL inrange32_word25 dout=%b want 11", dout0);
        end
        a = 5'd19;
        cyc();
        checks++;
        if (dout2 !== 2'b01) begin
            errors++;
            $display("FAIL oor_word19 dout=%b want 01", dout2);
        end
        a = 5'd5;
        cyc();
        checks++;
        if (dout2 !== 2'b00) begin
            errors++;
            $display("FAIL oor_alias5 dout=%b want 00", dout2);
        end
    endtask

    initial begin
        test_reset();
        test_bit_we();
        test_rdw();
        test_latch();
        test_clear();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
